// File: rtl/ps2_data_out.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then device acknowledge. Open-drain drive via *_oe (1 = pull low).
module ps2_data_out #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int unsigned MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned MAX_P = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] INH_DATA   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          data_s1_q, data_s2_q;
  logic          fe;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bits_q, bits_d;
  logic [7:0]    byte_q, byte_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          parity;

  assign fe     = clk_prev_q & ~clk_s2_q;
  assign parity = ~^byte_q;

  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    byte_d    = byte_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          byte_d    = tx_data;
          cnt_d     = CW'(1);
          clk_oe_d  = 1'b1;
          // A one-cycle inhibit must already present the start bit
          data_oe_d = (INHIBIT_CYCLES <= 1);
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q >= INH_LAST) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RTS;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == INH_DATA) data_oe_d = 1'b1;
        end
      end
      S_RTS: begin
        if (fe) begin
          data_oe_d = ~byte_q[0];
          bits_d    = 4'd1;
          cnt_d     = '0;
          state_d   = S_DATA;
        end else if (cnt_q >= START_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA, S_PARITY, S_ACK: begin
        // A falling edge takes priority over a timeout landing in the same cycle
        if (fe) begin
          if (state_q == S_DATA) begin
            if (bits_q == 4'd8) begin
              data_oe_d = ~parity;
              state_d   = S_PARITY;
            end else begin
              data_oe_d = ~byte_q[bits_q[2:0]];
            end
            bits_d = bits_q + 4'd1;
          end else if (state_q == S_PARITY) begin
            data_oe_d = 1'b0;
            bits_d    = 4'd10;
            state_d   = S_ACK;
          end else begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (!data_s2_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
        end else if (cnt_q >= XFER_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      byte_q    <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      byte_q    <= byte_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_ps2_data_out.sv
// Bench for ps2_data_out: behavioural PS/2 device on open-drain lines plus a
// frame-level reference model (start, LSB-first data, odd parity, stop).
`timescale 1ns/1ps
module tb_ps2_data_out;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2clk_in, ps2data_in;
  logic       ps2clk_oe, ps2data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int unsigned cyc = 0;
  int unsigned fall1_cyc = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int total = 0;
  int bad   = 0;

  localparam int HALF = 40;

  ps2_data_out #(.INHIBIT_CYCLES(10), .START_TIMEOUT(200), .XFER_TIMEOUT(4000)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
  );

  // Wired-AND of host and device drivers with pull-ups
  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_seen = done_seen + 1;
    if (tx_error === 1'b1) err_seen = err_seen + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device side: waits for request-to-send, clocks npulses, samples each bit
  // while the clock is low just before the rising edge, optionally acks pulse 11.
  task automatic dev_xfer(input int npulses, input bit ack,
                          output logic [10:0] frame, output bit found);
    frame = '0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) found = 1'b1;
    end
    if (found) begin
      repeat (5) @(negedge clk);
      frame[0] = ps2data_in;
      for (int p = 1; p <= npulses; p++) begin
        dev_clk_low = 1'b1;
        if (p == 11 && ack) dev_data_low = 1'b1;
        if (p == 1) fall1_cyc = cyc;
        repeat (HALF) @(negedge clk);
        if (p <= 10) frame[p] = ps2data_in;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_ready, tx_done, tx_error, ps2clk_oe, ps2data_oe} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_hold: got %b want 10000", {tx_ready, tx_done, tx_error, ps2clk_oe, ps2data_oe});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_ready, tx_done, tx_error, ps2clk_oe, ps2data_oe} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_after: got %b want 10000", {tx_ready, tx_done, tx_error, ps2clk_oe, ps2data_oe});
    end
  endtask

  task automatic test_idle_traffic;
    int errs;
    errs = 0;
    for (int p = 0; p < 11; p++) begin
      dev_clk_low = 1'b1; dev_data_low = p[0];
      repeat (6) @(negedge clk);
      if ({tx_ready, ps2clk_oe, ps2data_oe} !== 3'b100) errs++;
      dev_clk_low = 1'b0; dev_data_low = 1'b0;
      repeat (6) @(negedge clk);
      if ({tx_ready, ps2clk_oe, ps2data_oe} !== 3'b100) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL idle_traffic: got %0d driven samples want 0", errs);
    end
  endtask

  task automatic test_inhibit;
    logic [10:0] fr;
    bit found;
    int errs;
    errs = 0;
    start_byte(8'h55);
    for (int k = 1; k <= 11; k++) begin
      if (ps2clk_oe !== (k <= 10) || ps2data_oe !== (k >= 10) || tx_ready !== 1'b0) begin
        errs++;
        $display("FAIL inhibit_cycle%0d: got clk_oe=%b data_oe=%b ready=%b want %b %b 0",
                 k, ps2clk_oe, ps2data_oe, tx_ready, k <= 10, k >= 10);
      end
      if (k < 11) @(negedge clk);
    end
    total++;
    if (errs != 0) bad++;
    dev_xfer(11, 1'b1, fr, found);
    total++;
    if (!found || fr !== model_frame(8'h55)) begin
      bad++;
      $display("FAIL frame_55: got %b want %b", fr, model_frame(8'h55));
    end
  endtask

  task automatic test_ack_byte;
    logic [10:0] fr;
    bit found;
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    start_byte(8'hED);
    dev_xfer(11, 1'b1, fr, found);
    repeat (5) @(negedge clk);
    total++;
    if (!found || fr !== 11'b11_11101101_0 || fr !== model_frame(8'hED)) begin
      bad++;
      $display("FAIL frame_ED: got %b want %b", fr, 11'b11_11101101_0);
    end
    total++;
    if (done_seen - d0 !== 1 || err_seen - e0 !== 0) begin
      bad++;
      $display("FAIL pulses_ED: got done=%0d err=%0d want 1 0", done_seen - d0, err_seen - e0);
    end
  endtask

  task automatic test_parity;
    logic [10:0] fr;
    bit found;
    logic [7:0] vals [2];
    logic       par [2];
    int d0;
    vals[0] = 8'h01; par[0] = 1'b0;
    vals[1] = 8'hFF; par[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d0 = done_seen;
      start_byte(vals[i]);
      dev_xfer(11, 1'b1, fr, found);
      repeat (5) @(negedge clk);
      total++;
      if (!found || fr[9] !== par[i] || fr !== model_frame(vals[i]) || done_seen - d0 !== 1) begin
        bad++;
        $display("FAIL parity_%h: got frame %b done=%0d want parity %b done=1",
                 vals[i], fr, done_seen - d0, par[i]);
      end
    end
  endtask

  task automatic test_start_timeout;
    int n;
    int d0;
    d0 = done_seen;
    start_byte(8'h3C);
    for (int i = 0; i < 50 && ps2clk_oe === 1'b1; i++) @(negedge clk);
    n = 0;
    while (tx_error !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 200 || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin
      bad++;
      $display("FAIL start_timeout: got %0d cycles oe=%b%b want 200 cycles oe=00", n, ps2clk_oe, ps2data_oe);
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || tx_error !== 1'b0 || done_seen - d0 !== 0) begin
      bad++;
      $display("FAIL after_start_timeout: got ready=%b err=%b want 1 0", tx_ready, tx_error);
    end
  endtask

  task automatic test_no_ack;
    logic [10:0] fr;
    bit found;
    int d0, e0;
    d0 = done_seen; e0 = err_seen;
    start_byte(8'hA5);
    dev_xfer(11, 1'b0, fr, found);
    repeat (5) @(negedge clk);
    total++;
    if (!found || err_seen - e0 !== 1 || done_seen - d0 !== 0 ||
        ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || fr !== model_frame(8'hA5)) begin
      bad++;
      $display("FAIL no_ack: got err=%0d done=%0d frame=%b want 1 0 %b",
               err_seen - e0, done_seen - d0, fr, model_frame(8'hA5));
    end
  endtask

  task automatic test_stall;
    logic [10:0] fr;
    bit found;
    int n;
    int unsigned delta;
    start_byte(8'h96);
    dev_xfer(4, 1'b0, fr, found);
    n = 0;
    while (tx_error !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    delta = cyc - fall1_cyc;
    total++;
    if (!found || tx_error !== 1'b1 || delta < 3998 || delta > 4010 ||
        ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin
      bad++;
      $display("FAIL stall_timeout: got err=%b delta=%0d oe=%b%b want err=1 delta~4000 oe=00",
               tx_error, delta, ps2clk_oe, ps2data_oe);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [10:0] fr;
    bit found;
    int d0, e0;
    start_byte(8'h3A);
    dev_xfer(4, 1'b0, fr, found);
    d0 = done_seen; e0 = err_seen;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (!found || {tx_ready, tx_done, tx_error, ps2clk_oe, ps2data_oe} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_mid: got %b want 10000", {tx_ready, tx_done, tx_error, ps2clk_oe, ps2data_oe});
    end
    reset = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (done_seen - d0 !== 0 || err_seen - e0 !== 0 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pulses: got done=%0d err=%0d ready=%b want 0 0 1",
               done_seen - d0, err_seen - e0, tx_ready);
    end
  endtask

  task automatic test_busy_start;
    logic [10:0] fr;
    bit found;
    logic ready_at;
    int d0;
    d0 = done_seen;
    ready_at = 1'bx;
    start_byte(8'hA7);
    fork
      dev_xfer(11, 1'b1, fr, found);
      begin
        repeat (200) @(negedge clk);
        ready_at = tx_ready;
        tx_data  = 8'h12;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    total++;
    if (!found || ready_at !== 1'b0 || fr !== model_frame(8'hA7) || done_seen - d0 !== 1) begin
      bad++;
      $display("FAIL busy_start: got frame=%b ready=%b done=%0d want %b 0 1",
               fr, ready_at, done_seen - d0, model_frame(8'hA7));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  b   [5];
    logic [10:0] fr  [5];
    bit          fnd [5];
    logic        rdy [5];
    logic        coe [5];
    bit          got [5];
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      rdy[i] = 1'b1; coe[i] = 1'b1; got[i] = 1'b0;
    end
    start_byte(b[0]);
    for (int k = 0; k < 5; k++) begin
      fork
        dev_xfer(11, 1'b1, fr[k], fnd[k]);
        begin
          for (int n = 0; n < 2000 && !got[k]; n++) begin
            @(negedge clk);
            if (tx_done === 1'b1) got[k] = 1'b1;
          end
          if (k < 4) begin
            @(negedge clk);
            rdy[k]   = tx_ready;
            tx_data  = b[k+1];
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            coe[k]   = ps2clk_oe;
          end
        end
      join
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (!fnd[k] || !got[k] || fr[k] !== model_frame(b[k]) || rdy[k] !== 1'b1 || coe[k] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d: got frame=%b done=%b ready=%b clk_oe=%b want %b 1 1 1",
                 k, fr[k], got[k], rdy[k], coe[k], model_frame(b[k]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_traffic();
    test_inhibit();
    test_ack_byte();
    test_parity();
    test_start_timeout();
    test_no_ack();
    test_stall();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_data_out.md
# ps2_data_out

Host-to-device PS/2 transmitter. It sends one command byte, for example keyboard LED set 0xED or mouse reset 0xFF, to a PS/2 device over the shared open-drain ps2clk/ps2data lines, and reports acknowledge or failure. It pairs with the PS/2 receive block on the same lines. The top level turns each `*_oe` output into an open-drain driver: 1 drives the line to 0, 0 releases it to high-Z.

## Interface
- `INHIBIT_CYCLES`, default 5000: clk cycles that ps2clk is held low before request-to-send (100 µs at 50 MHz).
- `START_TIMEOUT`, default 750000: maximum clk cycles from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT`, default 100000: maximum clk cycles from the first falling edge to the 11th falling edge (2 ms).
- `clk`  in  1: single system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `tx_data`  in  8: byte to send; latched when `tx_start` is accepted.
- `tx_start`  in  1: one-cycle request; accepted only while `tx_ready`=1.
- `tx_ready`  out  1: transmitter idle, can accept `tx_start`.
- `tx_done`  out  1: one-cycle pulse; byte sent and device acknowledged.
- `tx_error`  out  1: one-cycle pulse; timeout or missing acknowledge.
- `ps2clk_in`  in  1: sampled ps2clk pin (asynchronous).
- `ps2data_in`  in  1: sampled ps2data pin (asynchronous).
- `ps2clk_oe`  out  1: 1 = pull ps2clk low.
- `ps2data_oe`  out  1: 1 = pull ps2data low.

## Operation
- **Input sync:** `ps2clk_in` and `ps2data_in` each pass through a 2-flop synchronizer. A falling edge (`fe`) is the previous synchronized ps2clk = 1 and the current = 0.
- **Outputs:** all registered.
- **Parity:** odd parity, computed as the XNOR-reduce of the latched byte.
- **Counters:** width is clog2 of the largest parameter plus 1. Counters never wrap; the bit counter runs 0..10.
- **IDLE:** both `oe`=0, `tx_ready`=1. On `tx_start`: latch `tx_data`, go to INHIBIT.
- **INHIBIT:** `ps2clk_oe`=1 for INHIBIT_CYCLES cycles. `ps2data_oe` rises on the last of those cycles (start bit = 0). Then go to RTS.
- **RTS:** `ps2clk_oe`=0, `ps2data_oe`=1, timeout counter runs.
  - First `fe`: drive bit0, go to DATA.
  - START_TIMEOUT reached: go to ERR.
- **DATA / PARITY / STOP:** on each `fe`, change data while the device holds the clock low.
  - `fe` 1..8 drive bits 0..7, LSB first, with `ps2data_oe` = NOT bit.
  - `fe` 9 drives parity, with `ps2data_oe` = NOT parity.
  - `fe` 10 releases data (`ps2data_oe`=0, stop bit = 1).
- **ACK:** on `fe` 11, sample synchronized ps2data.
  - 0: go to DONE.
  - 1: go to ERR.
- **Transfer timeout:** XFER_TIMEOUT runs from `fe` 1 through `fe` 11. Expiry in DATA, PARITY, STOP or ACK goes to ERR.
- **DONE / ERR:** one cycle; pulse `tx_done` or `tx_error`, both `oe`=0, then IDLE.
- **Boundary behaviour:**
  - `tx_start` while not ready is ignored; the latched byte is unchanged.
  - `fe` and timeout expiry in the same cycle: the edge wins.
  - Device-initiated traffic while IDLE is ignored; this block never drives while idle.

## Timing
- **Reset:** while `reset`=1 and on the following cycle, `tx_ready`=1 and `tx_done`=`tx_error`=`ps2clk_oe`=`ps2data_oe`=0. Reset mid-transfer releases both lines on the next edge of `clk` and abandons the byte with no `tx_error`.
- **Start:** `tx_start` sampled in cycle 0. In cycle 1, `tx_ready`=0 and `ps2clk_oe`=1. `ps2clk_oe` stays 1 through cycle INHIBIT_CYCLES. `ps2data_oe`=1 from cycle INHIBIT_CYCLES. `ps2clk_oe`=0 from cycle INHIBIT_CYCLES+1.
- **Edge latency:** pin falling edge to `fe` is 3 clk cycles. `ps2data_oe` updates in the cycle after `fe`.
- **Completion:** `tx_done`/`tx_error` are high for exactly one cycle. `tx_ready`=1 in the following cycle, and a new `tx_start` is accepted in that cycle.

## Test plan
Bench parameters: INHIBIT_CYCLES=10, START_TIMEOUT=200, XFER_TIMEOUT=4000. The device model clocks at 40-clk half-periods.

1. **Inhibit window:** `tx_start` with 0x55 -> `ps2clk_oe` high for exactly 10 cycles (1..10); `ps2data_oe` rises in cycle 10; clock released in cycle 11.
2. **Acknowledged byte:** `tx_data`=0xED, device model clocks and acks -> model captures 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one `tx_done` pulse; no `tx_error`.
3. **Parity polarity:** `tx_data`=0x01 -> model sees parity 0; `tx_data`=0xFF -> parity 1; both end in `tx_done`.
4. **Device silent / no ack:**
   - Device never clocks -> `tx_error` 200 cycles after clock release; both `oe`=0.
   - Device clocks but leaves data high at `fe` 11 -> `tx_error`.
5. **Device stall:** device stops clocking after bit 3 -> `tx_error` when XFER_TIMEOUT (4000 cycles) from `fe` 1 expires; lines released.
6. **Reset and busy start:**
   - `reset` asserted after `fe` 4 -> next cycle both `oe`=0 and `tx_ready`=1; no pulses.
   - `tx_start` with 0x12 asserted mid-transfer -> ignored; the original byte completes unchanged.
